// File: rtl/f_pc_ifid.sv
// Fetch PC register and IF/ID pipeline register.
// Generates the IM word address, flags bad fetches and counts fetch/stall cycles.
module f_pc_ifid #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter int          IM_ADDR_W = 12,
  parameter int          CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [31:0]          nPc,
  input  logic [31:0]          f_instr,
  output logic [31:0]          f_pc,
  output logic [IM_ADDR_W-1:0] f_im_addr,
  output logic                 f_fault,
  output logic [31:0]          d_pc,
  output logic [31:0]          d_instr,
  output logic                 d_valid,
  output logic                 fetch_err,
  output logic [CNT_W-1:0]     fetch_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // 33-bit end bound so a base near the top of memory cannot wrap
  localparam logic [32:0] IM_END =
    {1'b0, IM_BASE} + (33'd4 << IM_ADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] im_off;
  logic        mis_al;
  logic        below;
  logic        above;
  if_id_t      if_id_q;
  if_id_t      if_id_d;

  assign im_off    = f_pc - IM_BASE;
  assign f_im_addr = im_off[IM_ADDR_W+1:2];

  assign mis_al  = |f_pc[1:0];
  assign below   = f_pc < IM_BASE;
  assign above   = {1'b0, f_pc} >= IM_END;
  assign f_fault = mis_al | below | above;

  always_comb begin
    if_id_d = '{pc: f_pc, instr: f_instr, valid: 1'b1};
    unique case (1'b1)
      f_fault: begin
        if_id_d.instr = '0;
        if_id_d.valid = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_pc      <= PC_RESET;
      if_id_q   <= '0;
      fetch_err <= 1'b0;
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (stall) begin
      if (stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      f_pc    <= nPc;
      if_id_q <= if_id_d;
      if (f_fault)
        fetch_err <= 1'b1;
      if (fetch_cnt != CNT_MAX)
        fetch_cnt <= fetch_cnt + CNT_ONE;
    end
  end

  assign d_pc    = if_id_q.pc;
  assign d_instr = if_id_q.instr;
  assign d_valid = if_id_q.valid;

endmodule

// File: tb/tb_f_pc_ifid.sv
// Randomised bench for f_pc_ifid against a cycle-level reference model.
// Drives a 32-bit and a 4-bit counter instance from the same stimulus.
module tb_f_pc_ifid;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic [31:0] instr;

  logic [31:0] f_pc, d_pc, d_instr;
  logic [11:0] f_im_addr;
  logic        f_fault, d_valid, fetch_err;
  logic [31:0] fetch_cnt, stall_cnt;

  logic [31:0] f_pc4, d_pc4, d_instr4;
  logic [11:0] f_im_addr4;
  logic        f_fault4, d_valid4, fetch_err4;
  logic [3:0]  fetch_cnt4, stall_cnt4;

  int errors = 0;
  int checks = 0;

  f_pc_ifid dut (
    .clk(clk), .reset(reset), .stall(stall),
    .nPc(npc), .f_instr(instr),
    .f_pc(f_pc), .f_im_addr(f_im_addr),
    .f_fault(f_fault), .d_pc(d_pc),
    .d_instr(d_instr), .d_valid(d_valid),
    .fetch_err(fetch_err),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  f_pc_ifid #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall),
    .nPc(npc), .f_instr(instr),
    .f_pc(f_pc4), .f_im_addr(f_im_addr4),
    .f_fault(f_fault4), .d_pc(d_pc4),
    .d_instr(d_instr4), .d_valid(d_valid4),
    .fetch_err(fetch_err4),
    .fetch_cnt(fetch_cnt4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  bit          m_dv, m_err;
  longint      m_fetch, m_stall;

  function automatic bit m_flt(logic [31:0] pc);
    return (pc[1:0] != 2'b00) ||
           ({32'b0, pc} < 64'h3000) ||
           ({32'b0, pc} >= 64'h3000 + 64'd4 * 4096);
  endfunction

  function automatic logic [31:0] m_ima(logic [31:0] pc);
    return ((pc - 32'h3000) / 4) % 4096;
  endfunction

  function automatic logic [31:0] sat(longint c, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  task automatic m_reset();
    m_fpc = 32'h3000; m_dpc = 0; m_dinstr = 0;
    m_dv = 0; m_err = 0; m_fetch = 0; m_stall = 0;
  endtask

  task automatic m_edge(bit s, logic [31:0] n, logic [31:0] ins);
    bit flt;
    if (s) begin
      m_stall++;
    end else begin
      flt      = m_flt(m_fpc);
      m_dpc    = m_fpc;
      m_dinstr = flt ? 32'h0 : ins;
      m_dv     = !flt;
      m_err    = m_err | flt;
      m_fpc    = n;
      m_fetch++;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("f_pc",      f_pc,              m_fpc);
    chk("f_fault",   {31'b0, f_fault},  {31'b0, m_flt(m_fpc)});
    if (!m_flt(m_fpc))
      chk("f_im_addr", {20'b0, f_im_addr}, m_ima(m_fpc));
    chk("d_pc",      d_pc,              m_dpc);
    chk("d_instr",   d_instr,           m_dinstr);
    chk("d_valid",   {31'b0, d_valid},  {31'b0, m_dv});
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    chk("fetch_cnt", fetch_cnt,         sat(m_fetch, 32));
    chk("stall_cnt", stall_cnt,         sat(m_stall, 32));
    chk("f_pc4",     f_pc4,             m_fpc);
    chk("d_valid4",  {31'b0, d_valid4}, {31'b0, m_dv});
    chk("fetch_cnt4", {28'b0, fetch_cnt4}, sat(m_fetch, 4));
    chk("stall_cnt4", {28'b0, stall_cnt4}, sat(m_stall, 4));
  endtask

  // entered and left at posedge+1
  task automatic step(bit s, logic [31:0] n, logic [31:0] ins);
    stall = s; npc = n; instr = ins;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    m_edge(s, n, ins);
    #1;
  endtask

  // asynchronous reset in the middle of a cycle, released after one edge
  task automatic mid_reset();
    #3 reset = 0;
    #1 m_reset();
    compare_all();
    @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    logic [31:0] n;
    clk = 0; reset = 0; stall = 0; npc = 0; instr = 0;
    m_reset();

    // 1: reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    chk("rst_f_pc", f_pc, 32'h3000);
    chk("rst_d_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(posedge clk);
    #1 reset = 1;
    step(0, 32'h3004, 32'h2408_0001);
    chk("t1_f_pc", f_pc, 32'h3004);
    chk("t1_d_pc", d_pc, 32'h3000);
    chk("t1_d_instr", d_instr, 32'h2408_0001);
    chk("t1_d_valid", {31'b0, d_valid}, 32'h1);
    chk("t1_fetch_cnt", fetch_cnt, 32'h1);

    // 2: sequential run
    repeat (4) step(0, m_fpc + 4, $urandom);
    chk("t2_f_pc", f_pc, 32'h3014);
    chk("t2_d_pc", d_pc, 32'h3010);
    chk("t2_im_addr", {20'b0, f_im_addr}, 32'd5);

    // 3: stall hold
    n = d_instr;
    repeat (3) step(1, 32'h3100, $urandom);
    chk("t3_f_pc", f_pc, 32'h3014);
    chk("t3_d_pc", d_pc, 32'h3010);
    chk("t3_d_instr", d_instr, n);
    chk("t3_stall_cnt", stall_cnt, 32'd3);
    step(0, 32'h3100, $urandom);
    chk("t3_jump", f_pc, 32'h3100);

    // 4: misaligned fetch
    step(0, 32'h3002, $urandom);
    chk("t4_fault", {31'b0, f_fault}, 32'h1);
    step(0, 32'h3000, 32'hdead_beef);
    chk("t4_d_instr", d_instr, 32'h0);
    chk("t4_d_valid", {31'b0, d_valid}, 32'h0);
    chk("t4_err", {31'b0, fetch_err}, 32'h1);
    step(0, 32'h3004, $urandom);
    chk("t4_err_sticky", {31'b0, fetch_err}, 32'h1);
    chk("t4_valid_again", {31'b0, d_valid}, 32'h1);

    // 5: IM range boundaries
    step(0, 32'h7000, $urandom);
    chk("t5_hi_fault", {31'b0, f_fault}, 32'h1);
    step(0, 32'h6ffc, $urandom);
    chk("t5_last_ok", {31'b0, f_fault}, 32'h0);
    chk("t5_last_addr", {20'b0, f_im_addr}, 32'd4095);
    step(0, 32'h2ffc, $urandom);
    chk("t5_lo_fault", {31'b0, f_fault}, 32'h1);
    step(0, 32'h3000, $urandom);

    // 6: 4-bit counter saturation, then reset mid-stall
    repeat (20) step(0, m_fpc + 4, $urandom);
    chk("t6_sat4", {28'b0, fetch_cnt4}, 32'd15);
    repeat (2) step(1, $urandom, $urandom);
    stall = 1;
    #3 reset = 0;
    #1;
    chk("t6_fc", fetch_cnt, 32'h0);
    chk("t6_sc", stall_cnt, 32'h0);
    chk("t6_fc4", {28'b0, fetch_cnt4}, 32'h0);
    chk("t6_dv", {31'b0, d_valid}, 32'h0);
    chk("t6_err", {31'b0, fetch_err}, 32'h0);
    chk("t6_fpc", f_pc, 32'h3000);
    m_reset();
    @(posedge clk);
    #1 reset = 1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: n = m_fpc + 4;
        6, 7: n = 32'h3000 + 4 * $urandom_range(0, 4095);
        8: n = 32'h3000 + $urandom_range(0, 16383);
        default: n = $urandom;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        stall = $urandom_range(0, 1);
        mid_reset();
      end else begin
        step($urandom_range(0, 3) == 0, n, $urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
